and_gate_bist: RTL



---
 rtl/and_gate_bist.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/and_gate_bist.sv
// and_gate_bist: built-in self-test controller for a 2-input AND gate.
// Drives a/b into the gate, compares its response y against a golden
// a & b delayed by LAT cycles, and reports the mismatch count, the index of
// the first failing vector, and pass/fail.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   run request, sampled only in IDLE
//   a, b       out  gate inputs (registered)
//   y          in   gate output under test
//   busy       out  high in RUN and DRAIN
//   done       out  one-cycle pulse at end of run
//   pass       out  err_cnt == 0, valid from done until the next accepted start
//   err_cnt    out  saturating mismatch count
//   first_fail out  index of the first mismatching vector, 0 if none
module and_gate_bist #(
  parameter int N_VEC = 16,
  parameter int LAT   = 0,
  parameter int ERR_W = 8,
  parameter int IDX_W = (N_VEC > 1) ? $clog2(N_VEC) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [IDX_W-1:0] first_fail
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_VEC - 1);
  localparam logic [3:0]       LAST_DRAIN = 4'(LAT - 1);

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [3:0]       drain_q;
  logic             a_q, b_q, busy_q, done_q, pass_q;
  logic [ERR_W-1:0] err_q, err_d;
  logic [IDX_W-1:0] ff_q, ff_d;

  // Golden reference entering the delay pipe.
  logic             s0_valid, s0_exp;
  logic [IDX_W-1:0] s0_idx;
  // Golden reference aligned with the gate response.
  logic             d_valid, d_exp;
  logic [IDX_W-1:0] d_idx;
  logic             miss;

  assign s0_valid = (state_q == S_RUN);
  assign s0_exp   = a_q & b_q;
  assign s0_idx   = idx_q;

  generate
    if (LAT == 0) begin : g_nodelay
      assign d_valid = s0_valid;
      assign d_exp   = s0_exp;
      assign d_idx   = s0_idx;
    end else begin : g_delay
      logic [LAT-1:0]   pv_q;
      logic [LAT-1:0]   pe_q;
      logic [IDX_W-1:0] pi_q [LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pv_q <= '0;
          pe_q <= '0;
          for (int unsigned i = 0; i < LAT; i++) pi_q[i] <= '0;
        end else begin
          pv_q[0] <= s0_valid;
          pe_q[0] <= s0_exp;
          pi_q[0] <= s0_idx;
          for (int unsigned i = 1; i < LAT; i++) begin
            pv_q[i] <= pv_q[i-1];
            pe_q[i] <= pe_q[i-1];
            pi_q[i] <= pi_q[i-1];
          end
        end
      end

      assign d_valid = pv_q[LAT-1];
      assign d_exp   = pe_q[LAT-1];
      assign d_idx   = pi_q[LAT-1];
    end
  endgenerate

  assign miss = d_valid & (y ^ d_exp);

  always_comb begin
    err_d = err_q;
    ff_d  = ff_q;
    if (miss) begin
      if (err_q != '1) err_d = err_q + 1'b1;
      if (err_q == '0) ff_d = d_idx;
    end
  end

  // pass is loaded from err_d so the final compare, which lands on the same
  // edge that enters DONE, is already included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      drain_q <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ff_q    <= '0;
    end else begin
      err_q <= err_d;
      ff_q  <= ff_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_RUN;
            idx_q      <= '0;
            {a_q, b_q} <= 2'b00;
            busy_q     <= 1'b1;
            pass_q     <= 1'b0;
            err_q      <= '0;
            ff_q       <= '0;
          end
        end
        S_RUN: begin
          if (idx_q == LAST_IDX) begin
            {a_q, b_q} <= 2'b00;
            drain_q    <= '0;
            if (LAT > 0) begin
              state_q <= S_DRAIN;
            end else begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
            end
          end else begin
            idx_q      <= idx_q + 1'b1;
            // {a,b} tracks idx[1:0]; a separate 2-bit counter keeps it registered.
            {a_q, b_q} <= {a_q, b_q} + 2'd1;
          end
        end
        S_DRAIN: begin
          if (drain_q == LAST_DRAIN) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign a          = a_q;
  assign b          = b_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign first_fail = ff_q;

endmodule
